// File: rtl/lpset6_crc_if.sv
// lpset6_crc_if: serial bit stream and CRC result bundle between the TX state
// machine (master) and the CRC-15 generator (slave).
interface lpset6_crc_if;
    logic        start;  // high = accumulate data this cycle
    logic        data;   // serial tx bit
    logic        done;   // one-cycle pulse, r just updated
    logic [15:0] r;      // {crc[14:0], 1'b1}, bit 0 is the CRC delimiter

    modport master (output start, output data, input done, input r);
    modport slave  (input start, input data, output done, output r);
endinterface

// File: rtl/lpset6_crc.sv
// lpset6_crc: bit-serial CAN CRC-15 generator. Absorbs one tx bit per clock
// while start is high; on the falling edge of start it publishes
// {crc, 1'b1} on r and pulses done for one cycle.
// Optional feature: define LPSET6_MAXLEN_EN to cap a frame at MAX_BITS bits;
// the frame then completes on its own and the block holds until start drops.
module lpset6_crc #(
    parameter int              CRC_W = 15,
    parameter logic [CRC_W-1:0] POLY = 15'h4599,
    parameter logic [CRC_W-1:0] INIT = 15'h0000
`ifdef LPSET6_MAXLEN_EN
    ,
    parameter int              MAX_BITS = 127
`endif
) (
    input  logic        clock,
    input  logic        rst_n,
    lpset6_crc_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
`ifdef LPSET6_MAXLEN_EN
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [6:0] MAX_CNT  = 7'(MAX_BITS);
`endif

    logic [1:0]       state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic [CRC_W:0]   r_q, r_d;
    logic             done_q, done_d;
    logic             frame_end;
`ifdef LPSET6_MAXLEN_EN
    logic [6:0]       cnt_q, cnt_d;
`endif

    // One LFSR step: shift left, fold in the polynomial when the feedback is set.
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc,
                                                  input logic             bit_in);
        logic fb;
        fb = bit_in ^ crc[CRC_W-1];
        return {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    endfunction

    // A frame ends when start falls, or (when capped) when the bit budget is spent.
    always_comb begin
`ifdef LPSET6_MAXLEN_EN
        frame_end = !bus.start || (cnt_q == MAX_CNT);
`else
        frame_end = !bus.start;
`endif
    end

    // Next-state logic for the frame FSM, CRC register, result and done pulse.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves a latch behind.
        state_d = state_q;
        crc_d   = crc_q;
        r_d     = r_q;
        done_d  = 1'b0;
`ifdef LPSET6_MAXLEN_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    crc_d   = crc_step(INIT, bus.data);
                    state_d = ST_ACCUM;
`ifdef LPSET6_MAXLEN_EN
                    cnt_d   = 7'd1;
`endif
                end
            end
            ST_ACCUM: begin
                if (frame_end) begin
                    r_d    = {crc_q, 1'b1};
                    done_d = 1'b1;
`ifdef LPSET6_MAXLEN_EN
                    cnt_d   = 7'd0;
                    state_d = bus.start ? ST_HOLD : ST_IDLE;
`else
                    state_d = ST_IDLE;
`endif
                end else begin
                    crc_d = crc_step(crc_q, bus.data);
`ifdef LPSET6_MAXLEN_EN
                    cnt_d = cnt_q + 7'd1;
`endif
                end
            end
`ifdef LPSET6_MAXLEN_EN
            ST_HOLD: begin
                if (!bus.start) state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset aborts any frame in flight and clears the result.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            crc_q   <= INIT;
            r_q     <= '0;
            done_q  <= 1'b0;
`ifdef LPSET6_MAXLEN_EN
            cnt_q   <= 7'd0;
`endif
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q <= state_d;
            crc_q   <= crc_d;
            r_q     <= r_d;
            done_q  <= done_d;
`ifdef LPSET6_MAXLEN_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bus.r    = r_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_lpset6_crc.sv
// tb_lpset6_crc: directed and random frames against a frame-level model that
// computes the CAN CRC by polynomial long division of the collected bits.
module tb_lpset6_crc;
    logic clock = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    lpset6_crc_if bus ();

`ifdef LPSET6_MAXLEN_EN
    localparam int CAP = 2;
    lpset6_crc #(.MAX_BITS(CAP)) dut (.clock(clock), .rst_n(rst_n), .bus(bus));
`else
    localparam int CAP = 0;
    lpset6_crc dut (.clock(clock), .rst_n(rst_n), .bus(bus));
`endif

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // CRC as remainder of M(x)*x^15 divided by the full generator x^15+POLY.
    function automatic logic [14:0] crc_of(input bit msg[$]);
        bit          a[$];
        logic [15:0] gen;
        logic [14:0] rem;
        gen = 16'hC599;
        a = msg;
        for (int k = 0; k < 15; k++) a.push_back(1'b0);
        for (int i = 0; i + 16 <= a.size(); i++)
            if (a[i])
                for (int j = 0; j < 16; j++) a[i+j] = a[i+j] ^ gen[15-j];
        for (int k = 0; k < 15; k++) rem[14-k] = a[a.size()-15+k];
        return rem;
    endfunction

    // Frame-level reference model.
    bit          in_frame = 1'b0;
    bit          hold = 1'b0;
    bit          bits[$];
    logic        exp_done = 1'b0;
    logic [15:0] exp_r = 16'h0000;

    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            in_frame = 1'b0;
            hold     = 1'b0;
            bits.delete();
            exp_done = 1'b0;
            exp_r    = 16'h0000;
        end else begin
            exp_done = 1'b0;
            if (hold) begin
                if (!bus.start) hold = 1'b0;
            end else if (!in_frame) begin
                if (bus.start) begin
                    in_frame = 1'b1;
                    bits.delete();
                    bits.push_back(bus.data);
                end
            end else if (!bus.start || (CAP != 0 && bits.size() == CAP)) begin
                exp_r    = {crc_of(bits), 1'b1};
                exp_done = 1'b1;
                in_frame = 1'b0;
                hold     = bus.start;
            end else begin
                bits.push_back(bus.data);
            end
        end
    end

    // Continuous compare of DUT outputs against the model, away from the active edge.
    always @(negedge clock) begin
        check("cyc done", 32'(bus.done), 32'(exp_done));
        check("cyc r", 32'(bus.r), 32'(exp_r));
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            bus.start = 1'b0;
            bus.data  = 1'($urandom);
        end
    endtask

    // Sends v[n-1] first, then drops start for one cycle.
    task automatic send(input logic [127:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clock);
            bus.start = 1'b1;
            bus.data  = v[i];
        end
        @(negedge clock);
        bus.start = 1'b0;
        bus.data  = 1'($urandom);
    endtask

    task automatic expect_result(input string name, input logic [15:0] want);
        @(posedge clock);
        #1;
        check({name, " done"}, 32'(bus.done), 32'd1);
        check({name, " r"}, 32'(bus.r), 32'(want));
        check({name, " model"}, 32'(exp_r), 32'(want));
    endtask

    initial begin
        logic [127:0] v;
        int           n;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.data  = 1'b0;
        repeat (3) @(negedge clock);
        check("reset r", 32'(bus.r), 32'h0);
        check("reset done", 32'(bus.done), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            check("idle no done", 32'(bus.done), 32'h0);
        end

        send(128'h1, 1);
        expect_result("bit1", 16'h8B33);
        send(128'h0, 1);
        expect_result("bit0", 16'h0001);
        send(128'h2, 2);
        expect_result("bits10", 16'h9D57);
        @(posedge clock);
        #1;
        check("bits10 after done", 32'(bus.done), 32'h0);
        check("bits10 r held", 32'(bus.r), 32'h9D57);

`ifndef LPSET6_MAXLEN_EN
        v = 128'h0;
        v[15:0] = {1'b1, 15'h4599};
        send(v, 16);
        expect_result("residue", 16'h0001);
        send(128'h1, 1);
        expect_result("b2b bit1", 16'h8B33);
`endif

        // Reset while five bits are in flight.
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            bus.start = 1'b1;
            bus.data  = 1'($urandom);
        end
        @(negedge clock);
        rst_n = 1'b0;
        #1;
        check("midreset r", 32'(bus.r), 32'h0);
        check("midreset done", 32'(bus.done), 32'h0);
        @(negedge clock);
        bus.start = 1'b0;
        @(negedge clock);
        rst_n = 1'b1;
        send(128'h1, 1);
        expect_result("post reset bit1", 16'h8B33);

`ifdef LPSET6_MAXLEN_EN
        // Bits 1,0,1,1 with start held: completes after the 2nd bit, then holds.
        v = 128'hB;
        for (int i = 3; i >= 1; i--) begin
            @(negedge clock);
            bus.start = 1'b1;
            bus.data  = v[i];
        end
        expect_result("cap", 16'h9D57);
        @(negedge clock);
        bus.data = v[0];
        @(posedge clock);
        #1;
        check("cap hold no done", 32'(bus.done), 32'h0);
        idle(2);
`endif

        // Random frames, gaps and occasional mid-frame resets.
        for (int it = 0; it < 60; it++) begin
            v = {$urandom, $urandom, $urandom, $urandom};
            n = $urandom_range(1, 40);
            if ($urandom_range(0, 9) == 0) begin
                for (int i = 0; i < n; i++) begin
                    @(negedge clock);
                    bus.start = 1'b1;
                    bus.data  = v[i];
                end
                @(negedge clock);
                rst_n     = 1'b0;
                bus.start = 1'b0;
                @(negedge clock);
                rst_n = 1'b1;
            end else begin
                send(v, n);
                idle($urandom_range(0, 3));
            end
        end

        idle(3);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
